slc3_control_unit: RTL and testbench

//  Control FSM driving the SLC-3 datapath: issues every load enable, one-hot bus gate, mux select and ALU op.

---
 rtl/slc3_pkg.sv | 77 +++++++
 rtl/slc3_control_unit_if.sv | 31 +++
 rtl/slc3_control_unit_mem_wait_timer.sv | 25 ++
 rtl/slc3_control_unit.sv | 148 ++++++++++++++
 tb/tb_slc3_control_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 control definitions: FSM states, opcodes, mux/ALU encodings
// and the packed control word that the control unit drives onto the datapath.
package slc3_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S22, S12,
    S04, S20, S21,
    S06, S25, S27,
    S07, S23, S16,
    PAUSE_1, PAUSE_2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD    = 2'b00;
  localparam logic [1:0] ALUK_AND    = 2'b01;
  localparam logic [1:0] ALUK_NOT    = 2'b10;
  localparam logic [1:0] ALUK_PASS_A = 2'b11;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_BUS   = 2'b10;

  localparam logic [1:0] ADDR2MUX_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2MUX_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2MUX_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2MUX_OFF11 = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       sr2mux;
    logic       addr1mux;
    logic       drmux;
    logic       sr1mux;
    logic       marmux;
    logic       mio_en;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  // Idle control word: nothing loads, nothing drives the bus, SRAM strobes high.
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic logic is_wait_state(state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/slc3_control_unit_if.sv
// Control-unit <-> datapath signal bundle, including the Run/Continue buttons.
interface slc3_control_unit_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN,
    output PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX, MIO_EN,
    input  PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/slc3_control_unit_mem_wait_timer.sv
// Memory phase timer: start clears the count, done is high on the last of
// MEM_WAIT cycles after start. The count saturates rather than wrapping.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);
  localparam int unsigned W = $clog2(MEM_WAIT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_WAIT - 1);
  localparam logic [W-1:0] MAX  = W'(MEM_WAIT);

  logic [W-1:0] count;

  // Count cycles spent in the current wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (start)         count <= '0;
    else if (count != MAX)  count <= count + W'(1);
  end

  assign done = (count == LAST);
endmodule

// File: rtl/slc3_control_unit.sv
// SLC-3 control unit: Moore FSM sequencing fetch/decode/execute and pacing
// synchronous-SRAM accesses through mem_wait_timer.
module slc3_control_unit
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  slc3_control_unit_if.master  ctl
);
  state_t state, next;
  logic   done, start, pause_first;
  ctrl_t  c;

  // A wait state is entered only from a non-wait state, so this fires once per access.
  assign start = is_wait_state(next) && (next != state);

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .start (start),
    .done  (done)
  );

  // State register plus the flag marking the first cycle of PAUSE_1.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= HALTED;
      pause_first <= 1'b0;
    end else begin
      state       <= next;
      pause_first <= (next == PAUSE_1) && (state != PAUSE_1);
    end
  end

  // Next-state decode.
  always_comb begin
    next = state;
    case (state)
      HALTED:  if (ctl.Run) next = S18;
      S18:     next = S33;
      S33:     if (done) next = S35;
      S35:     next = S32;
      S32: begin
        case (ctl.Opcode)
          OP_ADD:   next = S01;
          OP_AND:   next = S05;
          OP_NOT:   next = S09;
          OP_BR:    next = ctl.BEN ? S22 : S18;
          OP_JMP:   next = S12;
          OP_JSR:   next = S04;
          OP_LDR:   next = S06;
          OP_STR:   next = S07;
          OP_PAUSE: next = PAUSE_1;
          default:  next = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S20, S21, S27: next = S18;
      S04:     next = ctl.IR_11 ? S21 : S20;
      S06:     next = S25;
      S25:     if (done) next = S27;
      S07:     next = S23;
      S23:     next = S16;
      S16:     if (done) next = S18;
      PAUSE_1: if (ctl.Continue) next = PAUSE_2;
      PAUSE_2: if (!ctl.Continue) next = S18;
      default: next = HALTED;
    endcase
  end

  // Moore output decode.
  always_comb begin
    c = ctrl_default();
    case (state)
      S18: begin
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_PC1; c.ld_pc = 1'b1;
      end
      S33, S25: begin
        c.mem_oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = done;
      end
      S35: begin
        c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
      end
      S32: c.ld_ben = 1'b1;
      S01, S05: begin
        c.sr1mux = 1'b1; c.sr2mux = ~ctl.IR_5;
        c.aluk = (state == S01) ? ALUK_ADD : ALUK_AND;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S09: begin
        c.sr1mux = 1'b1; c.aluk = ALUK_NOT;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S22: begin
        c.addr1mux = 1'b0; c.addr2mux = ADDR2MUX_OFF9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
      end
      S12, S20: begin
        c.sr1mux = 1'b1; c.aluk = ALUK_PASS_A; c.gate_alu = 1'b1;
        c.pcmux = PCMUX_BUS; c.ld_pc = 1'b1;
      end
      S04: begin
        c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
      end
      S21: begin
        c.addr1mux = 1'b0; c.addr2mux = ADDR2MUX_OFF11; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
      end
      S06, S07: begin
        c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = ADDR2MUX_OFF6;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      S27: begin
        c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S23: begin
        c.sr1mux = 1'b0; c.aluk = ALUK_PASS_A; c.gate_alu = 1'b1;
        c.ld_mdr = 1'b1; c.mio_en = 1'b0;
      end
      S16:     c.mem_we = 1'b0;
      PAUSE_1: c.ld_led = pause_first;
      default: ;
    endcase
  end

  assign ctl.LD_MAR     = c.ld_mar;
  assign ctl.LD_MDR     = c.ld_mdr;
  assign ctl.LD_IR      = c.ld_ir;
  assign ctl.LD_BEN     = c.ld_ben;
  assign ctl.LD_CC      = c.ld_cc;
  assign ctl.LD_REG     = c.ld_reg;
  assign ctl.LD_PC      = c.ld_pc;
  assign ctl.LD_LED     = c.ld_led;
  assign ctl.GatePC     = c.gate_pc;
  assign ctl.GateMDR    = c.gate_mdr;
  assign ctl.GateALU    = c.gate_alu;
  assign ctl.GateMARMUX = c.gate_marmux;
  assign ctl.SR2MUX     = c.sr2mux;
  assign ctl.ADDR1MUX   = c.addr1mux;
  assign ctl.DRMUX      = c.drmux;
  assign ctl.SR1MUX     = c.sr1mux;
  assign ctl.MARMUX     = c.marmux;
  assign ctl.MIO_EN     = c.mio_en;
  assign ctl.PCMUX      = c.pcmux;
  assign ctl.ADDR2MUX   = c.addr2mux;
  assign ctl.ALUK       = c.aluk;
  assign ctl.Mem_OE     = c.mem_oe;
  assign ctl.Mem_WE     = c.mem_we;
endmodule

// File: tb/tb_slc3_control_unit.sv
// Directed bench for slc3_control_unit with MEM_WAIT=3: table of instructions
// with hand-derived per-cycle control words, plus PAUSE and reset sequences.
module tb_slc3_control_unit;
  import slc3_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int unsigned applied = 0;
  int unsigned miscompares = 0;

  slc3_control_unit_if ctl ();

  slc3_control_unit #(.MEM_WAIT(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .ctl   (ctl)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic        ir5;
    logic        ir11;
    logic        ben;
    int unsigned n;
    ctrl_t [4:0] ex;
  } vec_t;

  ctrl_t cdef, c18, c33w, c33l, c35, c32, c_addi, c_addr, c_andi, c_not;
  ctrl_t c22, c12, c04, c21, c06, c27, c23, c16, cled;
  vec_t  vt [13];

  function automatic ctrl_t observe();
    ctrl_t a;
    a.ld_mar = ctl.LD_MAR;   a.ld_mdr = ctl.LD_MDR;   a.ld_ir = ctl.LD_IR;
    a.ld_ben = ctl.LD_BEN;   a.ld_cc = ctl.LD_CC;     a.ld_reg = ctl.LD_REG;
    a.ld_pc = ctl.LD_PC;     a.ld_led = ctl.LD_LED;
    a.gate_pc = ctl.GatePC;  a.gate_mdr = ctl.GateMDR;
    a.gate_alu = ctl.GateALU; a.gate_marmux = ctl.GateMARMUX;
    a.sr2mux = ctl.SR2MUX;   a.addr1mux = ctl.ADDR1MUX; a.drmux = ctl.DRMUX;
    a.sr1mux = ctl.SR1MUX;   a.marmux = ctl.MARMUX;   a.mio_en = ctl.MIO_EN;
    a.pcmux = ctl.PCMUX;     a.addr2mux = ctl.ADDR2MUX; a.aluk = ctl.ALUK;
    a.mem_oe = ctl.Mem_OE;   a.mem_we = ctl.Mem_WE;
    return a;
  endfunction

  function automatic vec_t mkv(logic [3:0] op, logic ir5, logic ir11, logic ben,
                               int unsigned n, ctrl_t e0, ctrl_t e1, ctrl_t e2,
                               ctrl_t e3, ctrl_t e4);
    vec_t v;
    v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben; v.n = n;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3; v.ex[4] = e4;
    return v;
  endfunction

  task automatic check_word(input string name, input ctrl_t exp);
    ctrl_t act;
    int unsigned gates;
    act = observe();
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
    gates = $countones({ctl.GatePC, ctl.GateMDR, ctl.GateALU, ctl.GateMARMUX});
    applied++;
    if (gates > 1) begin
      miscompares++;
      $display("FAIL %s bus gates: actual %0d high required <=1", name, gates);
    end
  endtask

  task automatic step(input string name, input ctrl_t exp);
    check_word(name, exp);
    @(negedge Clk);
  endtask

  task automatic fetch(input string name);
    step({name, " S18"}, c18);
    step({name, " S33a"}, c33w);
    step({name, " S33b"}, c33w);
    step({name, " S33c"}, c33l);
    step({name, " S35"}, c35);
    step({name, " S32"}, c32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    cdef = ctrl_default();
    c18 = cdef; c18.gate_pc = 1; c18.ld_mar = 1; c18.ld_pc = 1; c18.pcmux = 2'b00;
    c33w = cdef; c33w.mem_oe = 0; c33w.mio_en = 1;
    c33l = c33w; c33l.ld_mdr = 1;
    c35 = cdef; c35.gate_mdr = 1; c35.ld_ir = 1;
    c32 = cdef; c32.ld_ben = 1;
    c_addi = cdef; c_addi.sr1mux = 1; c_addi.sr2mux = 0; c_addi.aluk = 2'b00;
    c_addi.gate_alu = 1; c_addi.ld_reg = 1; c_addi.ld_cc = 1;
    c_addr = c_addi; c_addr.sr2mux = 1;
    c_andi = c_addi; c_andi.aluk = 2'b01;
    c_not = cdef; c_not.sr1mux = 1; c_not.aluk = 2'b10;
    c_not.gate_alu = 1; c_not.ld_reg = 1; c_not.ld_cc = 1;
    c22 = cdef; c22.addr2mux = 2'b10; c22.pcmux = 2'b01; c22.ld_pc = 1;
    c12 = cdef; c12.sr1mux = 1; c12.aluk = 2'b11; c12.gate_alu = 1;
    c12.pcmux = 2'b10; c12.ld_pc = 1;
    c04 = cdef; c04.gate_pc = 1; c04.drmux = 1; c04.ld_reg = 1;
    c21 = cdef; c21.addr2mux = 2'b11; c21.pcmux = 2'b01; c21.ld_pc = 1;
    c06 = cdef; c06.addr1mux = 1; c06.sr1mux = 1; c06.addr2mux = 2'b01;
    c06.gate_marmux = 1; c06.ld_mar = 1;
    c27 = cdef; c27.gate_mdr = 1; c27.ld_reg = 1; c27.ld_cc = 1;
    c23 = cdef; c23.aluk = 2'b11; c23.gate_alu = 1; c23.ld_mdr = 1;
    c16 = cdef; c16.mem_we = 0;
    cled = cdef; cled.ld_led = 1;

    vt[0]  = mkv(4'b0001, 1, 0, 0, 1, c_addi, cdef, cdef, cdef, cdef);
    vt[1]  = mkv(4'b0001, 0, 0, 0, 1, c_addr, cdef, cdef, cdef, cdef);
    vt[2]  = mkv(4'b0101, 1, 0, 0, 1, c_andi, cdef, cdef, cdef, cdef);
    vt[3]  = mkv(4'b1001, 0, 0, 1, 1, c_not,  cdef, cdef, cdef, cdef);
    vt[4]  = mkv(4'b0000, 0, 0, 0, 0, cdef,   cdef, cdef, cdef, cdef);
    vt[5]  = mkv(4'b0000, 0, 0, 1, 1, c22,    cdef, cdef, cdef, cdef);
    vt[6]  = mkv(4'b1100, 0, 0, 0, 1, c12,    cdef, cdef, cdef, cdef);
    vt[7]  = mkv(4'b0100, 0, 1, 0, 2, c04,    c21,  cdef, cdef, cdef);
    vt[8]  = mkv(4'b0100, 0, 0, 0, 2, c04,    c12,  cdef, cdef, cdef);
    vt[9]  = mkv(4'b0110, 0, 0, 0, 5, c06,    c33w, c33w, c33l, c27);
    vt[10] = mkv(4'b0111, 0, 0, 0, 5, c06,    c23,  c16,  c16,  c16);
    vt[11] = mkv(4'b1111, 0, 0, 1, 0, cdef,   cdef, cdef, cdef, cdef);
    vt[12] = mkv(4'b1000, 0, 0, 0, 0, cdef,   cdef, cdef, cdef, cdef);

    Reset = 1'b0;
    ctl.Run = 1'b1; ctl.Continue = 1'b0; ctl.Opcode = 4'b0000;
    ctl.IR_5 = 1'b0; ctl.IR_11 = 1'b0; ctl.BEN = 1'b0;

    repeat (2) @(negedge Clk);
    check_word("reset held", cdef);
    Reset = 1'b1;
    @(negedge Clk);
    ctl.Run = 1'b0;

    for (int unsigned i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      ctl.Opcode = vt[i].op; ctl.IR_5 = vt[i].ir5;
      ctl.IR_11 = vt[i].ir11; ctl.BEN = vt[i].ben;
      fetch(nm);
      for (int unsigned k = 0; k < vt[i].n; k++)
        step($sformatf("%s ex%0d", nm, k), vt[i].ex[k]);
    end

    ctl.Opcode = 4'b1101; ctl.Continue = 1'b0;
    fetch("pause");
    step("pause led", cled);
    for (int unsigned k = 0; k < 10; k++) step("pause hold", cdef);
    ctl.Continue = 1'b1;
    step("pause release", cdef);
    for (int unsigned k = 0; k < 5; k++) step("pause2 hold", cdef);
    ctl.Continue = 1'b0;
    step("pause2 exit", cdef);

    ctl.Opcode = 4'b0001; ctl.IR_5 = 1'b1;
    step("mid-read S18", c18);
    check_word("mid-read S33", c33w);
    #1 Reset = 1'b0;
    #1 check_word("async reset", cdef);
    ctl.Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int unsigned k = 0; k < 3; k++) step("halted idle", cdef);
    ctl.Run = 1'b1;
    step("halted run", cdef);
    fetch("restart");
    step("restart add", c_addi);
    check_word("restart back", c18);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
